// File: rtl/splash_controller.sv
// Fruit-splash overlay sequencer: commits a clamped sprite position on a frame tick,
// holds it for HOLD_FRAMES frames and emits a latency-aligned, colour-keyed overlay pixel.
// Optional build macro: SPLASH_FADE_EN (dims the sprite during the last quarter of the hold).
module splash_controller #(
  parameter int unsigned SPRITE_SIZE = 50,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned RAM_LAT     = 2,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slice_valid,
  input  logic [9:0]  slice_x,
  input  logic [8:0]  slice_y,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [11:0] sprite_color,
  output logic [9:0]  splash_x,
  output logic [8:0]  splash_y,
  output logic        active,
  output logic        pix_valid,
  output logic [11:0] pix_color
);

  localparam int unsigned CW = $clog2(HOLD_FRAMES);
  localparam logic [10:0] X_MAX = 11'(640 - SPRITE_SIZE);
  localparam logic [10:0] Y_MAX = 11'(480 - SPRITE_SIZE);
  localparam logic [CW-1:0] LAST_FRAME = CW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} stateT;

  stateT          state, stateNext;
  logic [9:0]     pendX, pendXNext, splashXNext;
  logic [8:0]     pendY, pendYNext, splashYNext;
  logic [CW-1:0]  frameCnt, frameCntNext;
  logic           restart, restartNext;
  logic [RAM_LAT-1:0] hitPipe;
  logic [9:0]     clampX;
  logic [8:0]     clampY;
  logic           hitNow, hitD;
  logic [11:0]    shaded;

  // Keep the whole sprite on the 640x480 screen
  assign clampX = ({1'b0, slice_x} > X_MAX) ? 10'(X_MAX) : slice_x;
  assign clampY = ({2'b00, slice_y} > Y_MAX) ? 9'(Y_MAX) : slice_y;

  // Tick is judged on pre-cycle state; a same-cycle slice is then layered on top
  always_comb begin
    stateNext    = state;
    pendXNext    = pendX;
    pendYNext    = pendY;
    splashXNext  = splash_x;
    splashYNext  = splash_y;
    frameCntNext = frameCnt;
    restartNext  = restart;
    case (state)
      IDLE: ;
      ARMED: begin
        if (frame_tick) begin
          splashXNext  = pendX;
          splashYNext  = pendY;
          frameCntNext = '0;
          stateNext    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_tick) begin
          if (restart) begin
            splashXNext  = pendX;
            splashYNext  = pendY;
            frameCntNext = '0;
            restartNext  = 1'b0;
          end else if (frameCnt == LAST_FRAME) begin
            stateNext = IDLE;
          end else begin
            frameCntNext = frameCnt + CW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (slice_valid) begin
      pendXNext = clampX;
      pendYNext = clampY;
      if (stateNext == ACTIVE) restartNext = 1'b1;
      else                     stateNext   = ARMED;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pendX    <= '0;
      pendY    <= '0;
      splash_x <= '0;
      splash_y <= '0;
      frameCnt <= '0;
      restart  <= 1'b0;
      active   <= 1'b0;
      hitPipe  <= '0;
    end else begin
      state    <= stateNext;
      pendX    <= pendXNext;
      pendY    <= pendYNext;
      splash_x <= splashXNext;
      splash_y <= splashYNext;
      frameCnt <= frameCntNext;
      restart  <= restartNext;
      active   <= (stateNext == ACTIVE);
      hitPipe  <= (hitPipe << 1) | RAM_LAT'(hitNow);
    end
  end

  // Widened sums so the window edge never wraps
  assign hitNow = active
                & ({1'b0, x} >= {1'b0, splash_x})
                & ({1'b0, x} <  ({1'b0, splash_x} + 11'(SPRITE_SIZE)))
                & ({1'b0, y} >= {1'b0, splash_y})
                & ({1'b0, y} <  ({1'b0, splash_y} + 10'(SPRITE_SIZE)));

  assign hitD = hitPipe[RAM_LAT-1];

`ifdef SPLASH_FADE_EN
  localparam logic [CW-1:0] FADE_START = CW'(HOLD_FRAMES - HOLD_FRAMES / 4);
  logic fadeOn;
  assign fadeOn = active & (frameCnt >= FADE_START);
  assign shaded = fadeOn ? {1'b0, sprite_color[11:9], 1'b0, sprite_color[7:5],
                            1'b0, sprite_color[3:1]}
                         : sprite_color;
`else
  assign shaded = sprite_color;
`endif

  assign pix_valid = hitD & (sprite_color != TRANSPARENT);
  assign pix_color = pix_valid ? shaded : 12'h000;

endmodule

// File: tb/tb_splash_controller.sv
// Scoreboard bench for splash_controller: stimulus queues hand-computed expectations
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_splash_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        slice_valid;
  logic [9:0]  slice_x;
  logic [8:0]  slice_y;
  logic        frame_tick;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] sprite_color;
  logic [9:0]  splash_x;
  logic [8:0]  splash_y;
  logic        active;
  logic        pix_valid;
  logic [11:0] pix_color;

  splash_controller dut (
    .clk(clk), .reset_n(reset_n), .slice_valid(slice_valid), .slice_x(slice_x),
    .slice_y(slice_y), .frame_tick(frame_tick), .x(x), .y(y),
    .sprite_color(sprite_color), .splash_x(splash_x), .splash_y(splash_y),
    .active(active), .pix_valid(pix_valid), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    logic        act;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic        pv;
    logic [11:0] pc;
  } expT;

  expT q[$];
  expT mon;
  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon = q.pop_front();
      checks++;
      if (mon.due == cyc && active === mon.act && splash_x === mon.sx &&
          splash_y === mon.sy && pix_valid === mon.pv && pix_color === mon.pc) begin
        passes++;
      end else begin
        $display("FAIL %s @cyc %0d (due %0d): got act=%0b sx=%0d sy=%0d pv=%0b pc=%h, want act=%0b sx=%0d sy=%0d pv=%0b pc=%h",
                 mon.tag, cyc, mon.due, active, splash_x, splash_y, pix_valid, pix_color,
                 mon.act, mon.sx, mon.sy, mon.pv, mon.pc);
      end
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
    slice_valid = 1'b0;
    frame_tick  = 1'b0;
  endtask

  task automatic expectNow(input string tag, input logic a, input logic [9:0] sx,
                           input logic [8:0] sy, input logic pv, input logic [11:0] pc);
    expT e;
    e.due = cyc; e.tag = tag; e.act = a; e.sx = sx; e.sy = sy; e.pv = pv; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic slice(input logic [9:0] sx, input logic [8:0] sy);
    slice_valid = 1'b1; slice_x = sx; slice_y = sy;
    clk1();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    clk1();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sliceTick(input logic [9:0] sx, input logic [8:0] sy);
    slice_valid = 1'b1; frame_tick = 1'b1; slice_x = sx; slice_y = sy;
    clk1();
  endtask

  // Present a pixel, feed its colour RAM_LAT (=2) cycles later, expect the overlay then
  task automatic pixel(input logic [9:0] px, input logic [8:0] py, input logic [11:0] col,
                       input string tag, input logic a, input logic [9:0] sx,
                       input logic [8:0] sy, input logic pv, input logic [11:0] pc);
    x = px; y = py;
    clk1();
    x = 10'd1023; y = 9'd511;
    clk1();
    sprite_color = col;
    expectNow(tag, a, sx, sy, pv, pc);
    clk1();
    sprite_color = 12'h000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; slice_valid = 1'b0; frame_tick = 1'b0;
    slice_x = '0; slice_y = '0; x = 10'd1023; y = 9'd511; sprite_color = 12'h000;
    clk1(); clk1();
    expectNow("reset_hold", 1'b0, 10'd0, 9'd0, 1'b0, 12'h000);
    clk1();
    reset_n = 1'b1;
    expectNow("reset_release", 1'b0, 10'd0, 9'd0, 1'b0, 12'h000);

    // Basic commit and hold
    slice(10'd100, 9'd200);
    expectNow("armed_no_commit", 1'b0, 10'd0, 9'd0, 1'b0, 12'h000);
    tick();
    expectNow("commit_100_200", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    checks++;
    if (splash_x === 10'd100 && splash_y === 9'd200) passes++;
    else $display("FAIL direct_commit: got sx=%0d sy=%0d, want sx=100 sy=200", splash_x, splash_y);
    pixel(10'd149, 9'd249, 12'h123, "pix_last_inside", 1'b1, 10'd100, 9'd200, 1'b1, 12'h123);
    pixel(10'd150, 9'd220, 12'h123, "pix_x_edge", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    pixel(10'd120, 9'd250, 12'h123, "pix_y_edge", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    pixel(10'd120, 9'd220, 12'h000, "pix_transparent", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    pixel(10'd99, 9'd220, 12'h123, "pix_left_of", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    ticks(29);
    expectNow("hold_29_ticks", 1'b1, 10'd100, 9'd200, 1'b0, 12'h000);
    tick();
    expectNow("expire_30th", 1'b0, 10'd100, 9'd200, 1'b0, 12'h000);
    checks++;
    if (active === 1'b0) passes++;
    else $display("FAIL direct_expire: got active=%0b, want active=0", active);

    // Clamping at the bottom-right corner
    slice(10'd630, 9'd470);
    expectNow("clamp_armed", 1'b0, 10'd100, 9'd200, 1'b0, 12'h000);
    tick();
    expectNow("clamp_commit", 1'b1, 10'd590, 9'd430, 1'b0, 12'h000);
    pixel(10'd639, 9'd479, 12'hFA0, "pix_corner", 1'b1, 10'd590, 9'd430, 1'b1, 12'hFA0);
    pixel(10'd590, 9'd430, 12'h000, "pix_corner_transp", 1'b1, 10'd590, 9'd430, 1'b0, 12'h000);
    pixel(10'd589, 9'd430, 12'hFFF, "pix_corner_left", 1'b1, 10'd590, 9'd430, 1'b0, 12'h000);

    // Restart beats expiry on the last tick
    ticks(29);
    expectNow("pre_expiry", 1'b1, 10'd590, 9'd430, 1'b0, 12'h000);
    slice(10'd10, 9'd10);
    expectNow("restart_no_tear", 1'b1, 10'd590, 9'd430, 1'b0, 12'h000);
    tick();
    expectNow("restart_commit", 1'b1, 10'd10, 9'd10, 1'b0, 12'h000);
    ticks(29);
    expectNow("restart_cnt_cleared", 1'b1, 10'd10, 9'd10, 1'b0, 12'h000);
    tick();
    expectNow("restart_expire", 1'b0, 10'd10, 9'd10, 1'b0, 12'h000);

    // Simultaneous slice and tick from IDLE only arms
    sliceTick(10'd200, 9'd100);
    expectNow("simul_armed", 1'b0, 10'd10, 9'd10, 1'b0, 12'h000);
    tick();
    expectNow("simul_commit", 1'b1, 10'd200, 9'd100, 1'b0, 12'h000);

    // Asynchronous reset with an opaque pixel on screen
    x = 10'd200; y = 9'd100;
    clk1(); clk1();
    sprite_color = 12'hFFF;
    expectNow("pre_reset_pix", 1'b1, 10'd200, 9'd100, 1'b1, 12'hFFF);
    clk1();
    reset_n = 1'b0;
    expectNow("async_reset", 1'b0, 10'd0, 9'd0, 1'b0, 12'h000);
    clk1(); clk1();
    reset_n = 1'b1;
    x = 10'd0; y = 9'd0;
    ticks(2);
    expectNow("post_reset_idle", 1'b0, 10'd0, 9'd0, 1'b0, 12'h000);
    sprite_color = 12'h000;
    x = 10'd1023; y = 9'd511;

    // Fade window starts at frame_cnt 23
    slice(10'd300, 9'd300);
    tick();
    ticks(22);
    pixel(10'd310, 9'd310, 12'hFA8, "fade_cnt22", 1'b1, 10'd300, 9'd300, 1'b1, 12'hFA8);
    tick();
`ifdef SPLASH_FADE_EN
    pixel(10'd310, 9'd310, 12'hFA8, "fade_cnt23", 1'b1, 10'd300, 9'd300, 1'b1, 12'h754);
`else
    pixel(10'd310, 9'd310, 12'hFA8, "fade_cnt23", 1'b1, 10'd300, 9'd300, 1'b1, 12'hFA8);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) clk1();
    while (q.size() > 0) begin
      mon = q.pop_front();
      checks++;
      $display("FAIL %s: got never compared, want compared at cyc %0d", mon.tag, mon.due);
    end
    $display("%0d/%0d checks passed", passes, checks);
    if (checks >= 12 && passes == checks) $display("PASS");
    else $display("FAIL summary: got %0d/%0d passed, want all of at least 12", passes, checks);
    $finish;
  end

endmodule

// File: doc/splash_controller.md
# splash_controller

Sequences the fruit-splash overlay sprite on the VGA pixel path. Accepts a slice event with the fruit's top-left position, commits a clamped splash position at the next frame boundary, and holds the splash for a fixed number of frames. Drives the position inputs of the splash image-setter stage and consumes its 12-bit pixel colour. Emits a latency-aligned, transparency-keyed overlay pixel for the display mux.

## Interface
Parameters:
- SPRITE_SIZE, 50: sprite edge length in pixels (square).
- HOLD_FRAMES, 30: number of frames the splash stays visible; must be ≥ 4.
- RAM_LAT, 2: cycles from pixel coordinate to valid colour at the image-setter output.
- TRANSPARENT, 12'h000: colour treated as transparent.

Ports:
- clk  in  1  pixel-pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- slice_valid  in  1  one-cycle pulse; a fruit was sliced.
- slice_x  in  10  fruit top-left x; sampled when slice_valid=1.
- slice_y  in  9  fruit top-left y; sampled when slice_valid=1.
- frame_tick  in  1  one-cycle pulse per frame, at the start of vertical blank.
- x  in  10  current pixel x.
- y  in  9  current pixel y.
- sprite_color  in  12  colour from the image setter, RAM_LAT cycles after x/y.
- splash_x  out  10  committed sprite x; feeds the image setter.
- splash_y  out  9  committed sprite y; feeds the image setter.
- active  out  1  splash currently displayed.
- pix_valid  out  1  overlay pixel is opaque and inside the sprite; aligned with sprite_color.
- pix_color  out  12  overlay colour; 0 when pix_valid=0.

## Operation
- States: IDLE, ARMED, ACTIVE.
- IDLE:
  - slice_valid stores clamped coordinates in the pending registers and moves to ARMED.
- ARMED:
  - frame_tick copies pending to splash_x/splash_y, clears frame_cnt, and moves to ACTIVE.
  - A further slice_valid overwrites pending; the last one before the tick wins.
- ACTIVE:
  - Each frame_tick increments frame_cnt.
  - The tick on which frame_cnt == HOLD_FRAMES-1 moves to IDLE; that tick does not commit anything.
  - A slice_valid sets restart and overwrites pending.
  - The next frame_tick with restart set commits pending, clears frame_cnt and restart, and stays in ACTIVE. Restart takes priority over expiry.
- Simultaneous slice_valid and frame_tick:
  - The tick is evaluated against the pre-cycle state.
  - The slice is then captured as pending/restart and takes effect at the following tick.
  - From IDLE, the result is ARMED.
- Clamping, done at capture:
  - pending_x = min(slice_x, 640-SPRITE_SIZE).
  - pending_y = min(slice_y, 480-SPRITE_SIZE).
  - Comparisons are 11-bit unsigned, so there is no wrap.
- Window hit (combinational on x,y):
  - x ≥ splash_x, x < splash_x+SPRITE_SIZE, y ≥ splash_y, y < splash_y+SPRITE_SIZE.
  - Sums are 11/10-bit wide so they do not wrap.
  - hit & active is delayed through a RAM_LAT-deep shift register to give hit_d.
- pix_valid = hit_d & (sprite_color != TRANSPARENT).
- pix_color = pix_valid ? sprite_color : 0.

## Timing
- Reset values (asynchronous, on reset_n low):
  - State IDLE; pending, splash_x, splash_y, frame_cnt, restart and the delay line all 0.
  - Outputs: active=0, pix_valid=0, pix_color=0.
- Reset mid-operation blanks the overlay immediately; the delay line is cleared.
- active rises the cycle after the committing frame_tick and falls the cycle after the expiring tick.
- The splash is visible for exactly HOLD_FRAMES frame_ticks, counted from commit.
- splash_x/splash_y change only on a frame_tick edge, so there is no tearing within a frame.
- pix_valid/pix_color are combinational from sprite_color and registered hit_d. Overlay latency equals RAM_LAT.

## Configuration
- SPLASH_FADE_EN defined:
  - While active and frame_cnt ≥ HOLD_FRAMES - HOLD_FRAMES/4, pix_color is each 4-bit channel of sprite_color shifted right by 1.
  - pix_valid is unchanged.
- SPLASH_FADE_EN undefined: pix_color is sprite_color unmodified for the full hold.

## Test plan
- Reset, then slice at (100,200) and a frame_tick → splash_x=100, splash_y=200, active=1 one cycle after the tick. After 30 further ticks → active=0.
- Slice at (630,470) → committed (590,430). Pixel (639,479) with sprite_color=12'hFA0 → pix_valid=1, pix_color=12'hFA0 exactly 2 cycles later.
- In ACTIVE at frame_cnt=29 (the expiring tick), slice at (10,10) → next tick restarts at (10,10) with frame_cnt=0, active stays 1. Same-cycle slice+tick from IDLE → ARMED, commit on the following tick.
- Pixel inside the window with sprite_color=12'h000 → pix_valid=0, pix_color=0. Pixel at x=splash_x+50 → pix_valid=0.
- Assert reset_n low mid-ACTIVE → all outputs 0 immediately. After release with no slice, ticks leave active=0.
- With SPLASH_FADE_EN, frame_cnt=23 and sprite_color=12'hFA8 → pix_color=12'h754. Without the macro → 12'hFA8.
